// File: rtl/mau_loader_if.sv
// mau_loader_if: bundles the host byte stream and the data-memory MAU port
// of the memory access unit.
//   rx_data/rx_valid/rx_ready : host command/data bytes into the loader
//   tx_data/tx_valid/tx_ready : read data and status bytes out to the host
//   mau_clk_en/mau_address/mau_data_write/mau_wren : memory access strobe
//   data_read                 : memory read word back to the loader
// Modports: master = the loader; slave = host UART plus data memory.
interface mau_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mau_clk_en;
    logic [31:0] mau_address;
    logic [31:0] mau_data_write;
    logic        mau_wren;
    logic [31:0] data_read;

    modport master (
        input  rx_data, rx_valid, tx_ready, data_read,
        output rx_ready, tx_data, tx_valid,
               mau_clk_en, mau_address, mau_data_write, mau_wren
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, data_read,
        input  rx_ready, tx_data, tx_valid,
               mau_clk_en, mau_address, mau_data_write, mau_wren
    );
endinterface

// File: rtl/mau_loader.sv
// mau_loader: memory access unit that lets a host write and read data memory
// over a byte stream while the CPU is held, and that owns the alive flag
// handing memory to the CPU.
// Commands: 0x01 WRITE, 0x02 READ (each followed by a 4-byte address and a
// 2-byte word count, little-endian), 0x03 RUN, 0x04 HALT; anything else NAKs.
// Ports:
//   clk      : system clock, shared with data memory
//   reset_n  : asynchronous active-low reset
//   bus      : mau_loader_if.master (host rx/tx byte streams, MAU memory port)
//   alive    : 0 = loader owns memory and CPU is held, 1 = CPU runs
// Parameters: RD_LAT (1..3 read latency), ACK_BYTE, NAK_BYTE.
// Optional: define MAU_CHECKSUM_EN to add a modulo-256 checksum over the data
// bytes of WRITE (checked, host sends it) and READ (sent before the status).
module mau_loader #(
    parameter int         RD_LAT   = 1,
    parameter logic [7:0] ACK_BYTE = 8'hA5,
    parameter logic [7:0] NAK_BYTE = 8'hEE
) (
    input  logic         clk,
    input  logic         reset_n,
    mau_loader_if.master bus,
    output logic         alive
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CNT,
        ST_WDATA,
        ST_WSTROBE,
        ST_RSTROBE,
        ST_RWAIT,
        ST_RSEND,
`ifdef MAU_CHECKSUM_EN
        ST_CHK,
`endif
        ST_RESP
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_t      state_reg, state_next;
    logic        out_en_reg;      // keeps rx_ready low until the first edge after reset
    logic        is_write_reg;
    logic        reject_reg;      // command arrived while the CPU was running
    logic        nak_reg;
    logic        alive_reg;
    logic [1:0]  byte_cnt_reg;
    logic [1:0]  wait_cnt_reg;
    logic [31:0] addr_reg;
    logic [15:0] count_reg;
    logic [31:0] word_reg;        // write word being assembled, or read word being sent
`ifdef MAU_CHECKSUM_EN
    logic [7:0]  sum_reg;
`endif

    logic        rx_ready, tx_valid, mau_clk_en, mau_wren;
    logic [7:0]  tx_data;
    logic        rx_fire, tx_fire, last_word, byte_last, cnt_zero;
    state_t      end_state;       // where a data phase goes once its last word is done

    assign rx_fire   = bus.rx_valid & rx_ready;
    assign tx_fire   = tx_valid & bus.tx_ready;
    assign last_word = (count_reg == 16'd1);
    assign byte_last = (byte_cnt_reg == 2'd3);
    assign cnt_zero  = ({bus.rx_data, count_reg[15:8]} == 16'd0);

`ifdef MAU_CHECKSUM_EN
    // A rejected READ never streams data, so it has no checksum to send.
    assign end_state = (!is_write_reg && reject_reg) ? ST_RESP : ST_CHK;
`else
    assign end_state = ST_RESP;
`endif

    assign bus.rx_ready       = rx_ready;
    assign bus.tx_valid       = tx_valid;
    assign bus.tx_data        = tx_data;
    assign bus.mau_clk_en     = mau_clk_en;
    assign bus.mau_wren       = mau_wren;
    assign bus.mau_address    = addr_reg;
    assign bus.mau_data_write = word_reg;
    assign alive              = alive_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        mau_clk_en = 1'b0;
        mau_wren   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                rx_ready = out_en_reg;
                if (rx_fire) begin
                    if (bus.rx_data == 8'h01 || bus.rx_data == 8'h02) begin
                        state_next = ST_ADDR;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                rx_ready = 1'b1;
                if (rx_fire && byte_last) begin
                    state_next = ST_CNT;
                end
            end
            ST_CNT: begin
                rx_ready = 1'b1;
                if (rx_fire && byte_cnt_reg == 2'd1) begin
                    if (cnt_zero) begin
                        state_next = end_state;
                    end else if (is_write_reg) begin
                        state_next = ST_WDATA;
                    end else if (reject_reg) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_RSTROBE;
                    end
                end
            end
            ST_WDATA: begin
                rx_ready = 1'b1;
                if (rx_fire && byte_last) begin
                    if (!reject_reg) begin
                        state_next = ST_WSTROBE;
                    end else if (last_word) begin
                        state_next = end_state;
                    end
                end
            end
            ST_WSTROBE: begin
                mau_clk_en = 1'b1;
                mau_wren   = 1'b1;
                state_next = last_word ? end_state : ST_WDATA;
            end
            ST_RSTROBE: begin
                mau_clk_en = 1'b1;
                state_next = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = ST_RSEND;
                end
            end
            ST_RSEND: begin
                tx_valid = 1'b1;
                tx_data  = word_reg[7:0];
                if (tx_fire && byte_last) begin
                    state_next = last_word ? end_state : ST_RSTROBE;
                end
            end
`ifdef MAU_CHECKSUM_EN
            ST_CHK: begin
                if (is_write_reg) begin
                    rx_ready = 1'b1;
                    if (rx_fire) begin
                        state_next = ST_RESP;
                    end
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = sum_reg;
                    if (tx_fire) begin
                        state_next = ST_RESP;
                    end
                end
            end
`endif
            ST_RESP: begin
                tx_valid = 1'b1;
                tx_data  = nak_reg ? NAK_BYTE : ACK_BYTE;
                if (tx_fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_en_reg   <= 1'b0;
            is_write_reg <= 1'b0;
            reject_reg   <= 1'b0;
            nak_reg      <= 1'b0;
            alive_reg    <= 1'b0;
            byte_cnt_reg <= 2'd0;
            wait_cnt_reg <= 2'd0;
            addr_reg     <= 32'd0;
            count_reg    <= 16'd0;
            word_reg     <= 32'd0;
`ifdef MAU_CHECKSUM_EN
            sum_reg      <= 8'h00;
`endif
        end else begin
            out_en_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (rx_fire) begin
                        byte_cnt_reg <= 2'd0;
                        is_write_reg <= (bus.rx_data == 8'h01);
                        reject_reg   <= alive_reg;
`ifdef MAU_CHECKSUM_EN
                        sum_reg      <= 8'h00;
`endif
                        case (bus.rx_data)
                            8'h01, 8'h02: nak_reg <= alive_reg;
                            8'h03: begin
                                nak_reg   <= 1'b0;
                                alive_reg <= 1'b1;
                            end
                            8'h04: begin
                                nak_reg   <= 1'b0;
                                alive_reg <= 1'b0;
                            end
                            default: nak_reg <= 1'b1;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        addr_reg     <= {bus.rx_data, addr_reg[31:8]};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                    end
                end
                ST_CNT: begin
                    if (rx_fire) begin
                        count_reg    <= {bus.rx_data, count_reg[15:8]};
                        byte_cnt_reg <= (byte_cnt_reg == 2'd1) ? 2'd0 : 2'd1;
                    end
                end
                ST_WDATA: begin
                    if (rx_fire) begin
                        word_reg     <= {bus.rx_data, word_reg[31:8]};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef MAU_CHECKSUM_EN
                        sum_reg      <= sum_reg + bus.rx_data;
`endif
                        // Rejected writes never strobe, so count words here instead.
                        if (byte_last && reject_reg) begin
                            count_reg <= count_reg - 16'd1;
                        end
                    end
                end
                ST_WSTROBE: begin
                    addr_reg  <= addr_reg + 32'd4;
                    count_reg <= count_reg - 16'd1;
                end
                ST_RSTROBE: begin
                    wait_cnt_reg <= 2'd0;
                end
                ST_RWAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + 2'd1;
                    if (wait_cnt_reg == WAIT_LAST) begin
                        word_reg <= bus.data_read;
                    end
                end
                ST_RSEND: begin
                    if (tx_fire) begin
                        word_reg     <= {8'h00, word_reg[31:8]};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef MAU_CHECKSUM_EN
                        sum_reg      <= sum_reg + word_reg[7:0];
`endif
                        if (byte_last) begin
                            addr_reg  <= addr_reg + 32'd4;
                            count_reg <= count_reg - 16'd1;
                        end
                    end
                end
`ifdef MAU_CHECKSUM_EN
                ST_CHK: begin
                    if (is_write_reg && rx_fire && bus.rx_data != sum_reg) begin
                        nak_reg <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mau_loader.sv
// tb_mau_loader: directed self-checking bench for mau_loader with a
// registered-read (RD_LAT=1) data memory model and a strobe monitor.
module tb_mau_loader;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic alive;

    mau_loader_if bus();

    mau_loader #(
        .RD_LAT   (1),
        .ACK_BYTE (8'hA5),
        .NAK_BYTE (8'hEE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .alive   (alive)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Data memory: registered read, one-cycle latency.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mau_clk_en) begin
            if (bus.mau_wren) begin
                mem[bus.mau_address[9:2]] <= bus.mau_data_write;
            end else begin
                bus.data_read <= mem[bus.mau_address[9:2]];
            end
        end
    end

    // Strobe monitor, sampled mid-cycle.
    typedef struct packed {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] data;
    } strobe_t;
    strobe_t strobes[$];
    int  n_back2back = 0;
    int  n_alive_strobe = 0;
    bit  prev_en = 1'b0;

    always @(negedge clk) begin
        if (bus.mau_clk_en) begin
            strobes.push_back({bus.mau_wren, bus.mau_address, bus.mau_data_write});
            if (prev_en) n_back2back++;
            if (alive) n_alive_strobe++;
        end
        prev_en = bus.mau_clk_en;
    end

    // Stimulus helpers (called and returning at a falling edge).
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_mis++;
            $display("FAIL rx_timeout: byte %h not accepted, required acceptance within 300 cycles", b);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] a, input logic [15:0] n);
        send_byte(cmd);
        send_word(a);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic recv_byte(output logic [7:0] b, input bit slow);
        int t;
        bit got;
        t = 0;
        got = 1'b0;
        b = 8'h00;
        while (!got && t < 300) begin
            bus.tx_ready = slow ? ~bus.tx_ready : 1'b1;
            if (bus.tx_valid && bus.tx_ready) begin
                b = bus.tx_data;
                got = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        bus.tx_ready = 1'b0;
        if (!got) begin
            n_cmp++;
            n_mis++;
            $display("FAIL tx_timeout: no byte seen, required one within 300 cycles");
        end
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({alive, bus.rx_ready, bus.tx_valid, bus.mau_clk_en, bus.mau_wren} !== 5'b0) begin
            n_mis++;
            $display("FAIL reset_ctrl: got %b required 00000", {alive, bus.rx_ready, bus.tx_valid, bus.mau_clk_en, bus.mau_wren});
        end
        n_cmp++;
        if (bus.tx_data !== 8'h00) begin
            n_mis++;
            $display("FAIL reset_tx_data: got %h required 00", bus.tx_data);
        end
        n_cmp++;
        if (bus.mau_address !== 32'h0) begin
            n_mis++;
            $display("FAIL reset_addr: got %h required 00000000", bus.mau_address);
        end
        n_cmp++;
        if (bus.mau_data_write !== 32'h0) begin
            n_mis++;
            $display("FAIL reset_wdata: got %h required 00000000", bus.mau_data_write);
        end
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.rx_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL idle_rx_ready: got %b required 1", bus.rx_ready);
        end
        $display("reset: done, compared=%0d", n_cmp);
    endtask

    task automatic test_write();
        logic [7:0] b;
        strobes.delete();
        send_hdr(8'h01, 32'h0000_0100, 16'd2);
        send_word(32'h1122_3344);
        send_word(32'hAABB_CCDD);
`ifdef MAU_CHECKSUM_EN
        send_byte(8'hB8);
`endif
        recv_byte(b, 1'b0);
        n_cmp++;
        if (b !== 8'hA5) begin
            n_mis++;
            $display("FAIL write_ack: got %h required a5", b);
        end
        n_cmp++;
        if (strobes.size() != 2) begin
            n_mis++;
            $display("FAIL write_nstrobe: got %0d required 2", strobes.size());
        end else begin
            n_cmp++;
            if (strobes[0] !== {1'b1, 32'h0000_0100, 32'h1122_3344}) begin
                n_mis++;
                $display("FAIL write_strobe0: got %h required %h", strobes[0], {1'b1, 32'h0000_0100, 32'h1122_3344});
            end
            n_cmp++;
            if (strobes[1] !== {1'b1, 32'h0000_0104, 32'hAABB_CCDD}) begin
                n_mis++;
                $display("FAIL write_strobe1: got %h required %h", strobes[1], {1'b1, 32'h0000_0104, 32'hAABB_CCDD});
            end
        end
        $display("write: addr 00000100 n=2 ack=%h strobes=%0d", b, strobes.size());
    endtask

    task automatic test_read();
        logic [7:0] b;
        logic [7:0] exp_b [0:9];
        int nb;
        exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
        exp_b[4] = 8'hDD; exp_b[5] = 8'hCC; exp_b[6] = 8'hBB; exp_b[7] = 8'hAA;
`ifdef MAU_CHECKSUM_EN
        exp_b[8] = 8'hB8; exp_b[9] = 8'hA5; nb = 10;
`else
        exp_b[8] = 8'hA5; exp_b[9] = 8'h00; nb = 9;
`endif
        strobes.delete();
        send_hdr(8'h02, 32'h0000_0100, 16'd2);
        for (int i = 0; i < nb; i++) begin
            recv_byte(b, 1'b1);
            n_cmp++;
            if (b !== exp_b[i]) begin
                n_mis++;
                $display("FAIL read_byte%0d: got %h required %h", i, b, exp_b[i]);
            end
        end
        n_cmp++;
        if (strobes.size() != 2) begin
            n_mis++;
            $display("FAIL read_nstrobe: got %0d required 2", strobes.size());
        end else begin
            n_cmp++;
            if (strobes[0][64:32] !== {1'b0, 32'h0000_0100}) begin
                n_mis++;
                $display("FAIL read_strobe0: got %h required %h", strobes[0][64:32], {1'b0, 32'h0000_0100});
            end
            n_cmp++;
            if (strobes[1][64:32] !== {1'b0, 32'h0000_0104}) begin
                n_mis++;
                $display("FAIL read_strobe1: got %h required %h", strobes[1][64:32], {1'b0, 32'h0000_0104});
            end
        end
        $display("read: addr 00000100 n=2 bytes=%0d strobes=%0d", nb, strobes.size());
    endtask

    task automatic test_run_reject();
        logic [7:0] b;
        send_byte(8'h03);
        n_cmp++;
        if (alive !== 1'b1) begin
            n_mis++;
            $display("FAIL run_alive: got %b required 1", alive);
        end
        recv_byte(b, 1'b0);
        n_cmp++;
        if (b !== 8'hA5) begin
            n_mis++;
            $display("FAIL run_ack: got %h required a5", b);
        end
        strobes.delete();
        send_hdr(8'h01, 32'h0000_0000, 16'd1);
        send_word(32'h5566_7788);
`ifdef MAU_CHECKSUM_EN
        send_byte(8'h00);
`endif
        recv_byte(b, 1'b0);
        n_cmp++;
        if (b !== 8'hEE) begin
            n_mis++;
            $display("FAIL busy_write_nak: got %h required ee", b);
        end
        n_cmp++;
        if (strobes.size() != 0) begin
            n_mis++;
            $display("FAIL busy_write_strobes: got %0d required 0", strobes.size());
        end
        send_byte(8'h04);
        n_cmp++;
        if (alive !== 1'b0) begin
            n_mis++;
            $display("FAIL halt_alive: got %b required 0", alive);
        end
        recv_byte(b, 1'b0);
        n_cmp++;
        if (b !== 8'hA5) begin
            n_mis++;
            $display("FAIL halt_ack: got %h required a5", b);
        end
        $display("run/reject/halt: alive=%b", alive);
    endtask

    task automatic test_unknown_wrap();
        logic [7:0] b;
        send_byte(8'h7F);
        recv_byte(b, 1'b0);
        n_cmp++;
        if (b !== 8'hEE) begin
            n_mis++;
            $display("FAIL unknown_nak: got %h required ee", b);
        end
        $display("unknown: cmd 7f resp=%h", b);
        strobes.delete();
        send_hdr(8'h01, 32'hFFFF_FFFC, 16'd2);
        send_word(32'h0102_0304);
        send_word(32'h0506_0708);
`ifdef MAU_CHECKSUM_EN
        send_byte(8'h24);
`endif
        recv_byte(b, 1'b0);
        n_cmp++;
        if (b !== 8'hA5) begin
            n_mis++;
            $display("FAIL wrap_ack: got %h required a5", b);
        end
        n_cmp++;
        if (strobes.size() != 2) begin
            n_mis++;
            $display("FAIL wrap_nstrobe: got %0d required 2", strobes.size());
        end else begin
            n_cmp++;
            if (strobes[0] !== {1'b1, 32'hFFFF_FFFC, 32'h0102_0304}) begin
                n_mis++;
                $display("FAIL wrap_strobe0: got %h required %h", strobes[0], {1'b1, 32'hFFFF_FFFC, 32'h0102_0304});
            end
            n_cmp++;
            if (strobes[1] !== {1'b1, 32'h0000_0000, 32'h0506_0708}) begin
                n_mis++;
                $display("FAIL wrap_strobe1: got %h required %h", strobes[1], {1'b1, 32'h0000_0000, 32'h0506_0708});
            end
        end
        $display("wrap: addr fffffffc n=2 ack=%h", b);
    endtask

    task automatic test_n_zero();
        logic [7:0] b;
        strobes.delete();
        send_hdr(8'h02, 32'h0000_0040, 16'd0);
`ifdef MAU_CHECKSUM_EN
        recv_byte(b, 1'b0);
        n_cmp++;
        if (b !== 8'h00) begin
            n_mis++;
            $display("FAIL nzero_sum: got %h required 00", b);
        end
`endif
        recv_byte(b, 1'b0);
        n_cmp++;
        if (b !== 8'hA5) begin
            n_mis++;
            $display("FAIL nzero_ack: got %h required a5", b);
        end
        n_cmp++;
        if (strobes.size() != 0) begin
            n_mis++;
            $display("FAIL nzero_strobes: got %0d required 0", strobes.size());
        end
        $display("read n=0: resp=%h", b);
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        strobes.delete();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.rx_ready, bus.mau_clk_en, alive} !== 3'b000) begin
            n_mis++;
            $display("FAIL midreset_outs: got %b required 000", {bus.rx_ready, bus.mau_clk_en, alive});
        end
        reset_n = 1'b1;
        @(negedge clk);
        send_byte(8'h04);
        recv_byte(b, 1'b0);
        n_cmp++;
        if (b !== 8'hA5) begin
            n_mis++;
            $display("FAIL midreset_halt_ack: got %h required a5", b);
        end
        n_cmp++;
        if (strobes.size() != 0) begin
            n_mis++;
            $display("FAIL midreset_strobes: got %0d required 0", strobes.size());
        end
        $display("mid-transfer reset: recovery resp=%h", b);
    endtask

`ifdef MAU_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] b;
        strobes.delete();
        send_hdr(8'h01, 32'h0000_0200, 16'd1);
        send_word(32'h0403_0201);
        send_byte(8'h0A);
        recv_byte(b, 1'b0);
        n_cmp++;
        if (b !== 8'hA5) begin
            n_mis++;
            $display("FAIL chk_good_ack: got %h required a5", b);
        end
        send_hdr(8'h01, 32'h0000_0204, 16'd1);
        send_word(32'h0403_0201);
        send_byte(8'h0B);
        recv_byte(b, 1'b0);
        n_cmp++;
        if (b !== 8'hEE) begin
            n_mis++;
            $display("FAIL chk_bad_nak: got %h required ee", b);
        end
        n_cmp++;
        if (strobes.size() != 2) begin
            n_mis++;
            $display("FAIL chk_nstrobe: got %0d required 2", strobes.size());
        end else begin
            n_cmp++;
            if (strobes[1] !== {1'b1, 32'h0000_0204, 32'h0403_0201}) begin
                n_mis++;
                $display("FAIL chk_bad_written: got %h required %h", strobes[1], {1'b1, 32'h0000_0204, 32'h0403_0201});
            end
        end
        $display("checksum: good/bad write done, last resp=%h", b);
    endtask
`endif

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_run_reject();
        test_unknown_wrap();
        test_n_zero();
`ifdef MAU_CHECKSUM_EN
        test_checksum();
`endif
        test_mid_reset();
        n_cmp++;
        if (n_back2back != 0) begin
            n_mis++;
            $display("FAIL strobe_spacing: got %0d back-to-back strobes required 0", n_back2back);
        end
        n_cmp++;
        if (n_alive_strobe != 0) begin
            n_mis++;
            $display("FAIL strobe_while_alive: got %0d required 0", n_alive_strobe);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mau_loader.md
Name: mau_loader

Overview:
- Memory access unit (MAU) that lets a host load and inspect data memory over a byte stream while the CPU is held.
- Decodes host command bytes from a host UART byte receiver.
- Drives the MAU port of data memory: mau_clk_en, mau_address, mau_data_write, mau_wren; takes back data_read.
- Streams read data and status bytes to a host UART byte transmitter.
- Owns the alive signal that hands memory ownership to the CPU.

Parameters:
- RD_LAT, 1: cycles from a read strobe (mau_clk_en=1, mau_wren=0) to valid data_read; legal values 1..3.
- ACK_BYTE, 8'hA5: status byte sent on successful command completion.
- NAK_BYTE, 8'hEE: status byte sent on a rejected or failed command.

Ports:
- clk  in  1  system clock, shared with data memory.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  host byte.
- rx_valid  in  1  rx_data valid; a byte is consumed when rx_valid & rx_ready.
- rx_ready  out  1  MAU can accept a byte.
- tx_data  out  8  byte to host.
- tx_valid  out  1  tx_data valid; held until tx_ready.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- mau_clk_en  out  1  memory access strobe, one cycle per word.
- mau_address  out  32  byte address; memory decodes [15:2].
- mau_data_write  out  32  write word.
- mau_wren  out  1  write enable; only meaningful with mau_clk_en.
- data_read  in  32  memory read word.
- alive  out  1  0 = MAU owns memory and CPU is held; 1 = CPU runs.

Behaviour:
- Reset is asynchronous, active-low and already decided; clock port is clk, reset port is reset_n.
- Reset values: alive=0, rx_ready=0, tx_valid=0, tx_data=0, mau_clk_en=0, mau_wren=0, mau_address=0, mau_data_write=0; state=IDLE. Reset mid-transfer abandons the transfer; no partial word is written.
- Commands (first byte):
  - 0x01 WRITE
  - 0x02 READ
  - 0x03 RUN: alive<=1, then ACK.
  - 0x04 HALT: alive<=0, then ACK.
  - Any other byte: NAK, return to IDLE.
- WRITE/READ header: 4 address bytes, then 2 count bytes N (words). All little-endian.
- The address is used as given; bits [1:0] are ignored by memory.
- N=0: no memory access, immediate ACK.
- WRITE or READ received while alive=1: NAK, and the header and data bytes are still consumed and discarded.
- States: IDLE, ADDR(4 bytes), CNT(2 bytes), WDATA, WSTROBE, RSTROBE, RWAIT, RSEND, [CHK], RESP.
- rx_ready=1 only in IDLE, ADDR, CNT, WDATA and CHK(WRITE); 0 elsewhere.
- WRITE path:
  - WDATA collects 4 bytes, LSB first.
  - WSTROBE then holds mau_clk_en=1, mau_wren=1 and mau_data_write=word for exactly 1 cycle.
  - Next: mau_address += 4 and the remaining count decrements.
  - Loops to WDATA until the count reaches 0, then goes to RESP.
- READ path:
  - RSTROBE holds mau_clk_en=1, mau_wren=0 for 1 cycle.
  - RWAIT lasts RD_LAT cycles; data_read is captured at the end of RWAIT.
  - RSEND emits 4 bytes LSB first, each held until tx_ready.
  - Then address += 4; the next word's strobe is issued only after its 4th byte is accepted.
- Address arithmetic is 32-bit modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000); no error on wrap.
- RESP drives tx_valid=1 with ACK_BYTE or NAK_BYTE until tx_ready, then returns to IDLE.
- mau_clk_en is never high in two consecutive cycles.
- mau_address and mau_data_write stay stable while mau_clk_en=1.
- A change of alive takes effect the cycle after the RUN or HALT byte is accepted, and no mau_clk_en strobe is issued while alive=1.
- Simultaneous rx_valid in a non-accepting state: the byte is ignored (rx_ready=0); the sender must hold it.

Optional Feature:
- Macro: MAU_CHECKSUM_EN.
- Defined:
  - Running 8-bit modulo-256 sum over all data bytes of a WRITE/READ (header excluded).
  - WRITE: a checksum byte follows the data. Match gives ACK, mismatch gives NAK; words already written stay written.
  - READ: the sum byte is sent after the data and before ACK.
  - N=0: checksum 0x00.
- Undefined: no CHK state, no checksum bytes; sum logic absent.

Test Plan:
- Reset with alive checked -> after reset_n rises: alive=0, all outputs 0, first command byte accepted.
- WRITE addr 0x00000100 N=2, data 0x11223344, 0xAABBCCDD -> strobe 1 at 0x100 with 0x11223344, strobe 2 at 0x104 with 0xAABBCCDD, mau_wren=1 each, then tx 0xA5.
- READ addr 0x100 N=2 after the write, RD_LAT=1 memory model, tx_ready toggling every other cycle -> tx 44 33 22 11 DD CC BB AA A5, one strobe per word with mau_wren=0.
- RUN then WRITE addr 0 N=1 -> alive=1 and ACK, then NAK after 4 data bytes consumed, no mau_clk_en pulse; HALT -> alive=0, ACK.
- Unknown byte 0x7F -> NAK 0xEE; WRITE addr 0xFFFFFFFC N=2 -> strobes at 0xFFFFFFFC then 0x00000000.
- With MAU_CHECKSUM_EN: WRITE N=1 data 01 02 03 04, checksum 0x0A -> ACK; checksum 0x0B -> word still written, NAK.
